// File: rtl/xbar_input_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | xbar_input_buffer: double-banked header/payload frame buffer feeding the |
// | crossbar scheduler. Optional: XBAR_PERR_CNT_EN (per-port parity counters)|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module xbar_input_buffer #(
  parameter int PORTS = 8,
  parameter int SLOTS = 4,
  parameter int PKT_W = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
`ifdef XBAR_PERR_CNT_EN
  input  logic                                         i_perr_clr,
  output logic [PORTS*8-1:0]                           o_perr_cnt,
`endif
  input  logic                                         i_sym_en,
  input  logic                                         i_frame_start,
  input  logic [PORTS*PKT_W-1:0]                       i_decoded_in,
  input  logic [(PORTS > 1 ? $clog2(PORTS) : 1)-1:0]   i_rd_port,
  input  logic [(SLOTS > 1 ? $clog2(SLOTS) : 1)-1:0]   i_rd_slot,
  output logic [PKT_W-1:0]                             o_rd_header,
  output logic [PKT_W-1:0]                             o_rd_payload,
  output logic                                         o_rd_valid,
  output logic                                         o_bank_sel,
  output logic [(SLOTS > 1 ? $clog2(SLOTS) : 1)-1:0]   o_running_slot,
  output logic                                         o_frame_done,
  output logic [PORTS-1:0]                             o_hdr_perr,
  output logic                                         o_sync_err
);

  localparam int c_PORT_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int c_SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_SLOT_W-1:0]   r_slot;
  logic                  r_bank;
  logic                  r_rd_valid;
  logic                  r_frame_done;
  logic                  r_sync_err;
  logic [PORTS-1:0]      r_hdr_perr;
  logic [PKT_W-1:0]      r_rd_header;
  logic [PKT_W-1:0]      r_rd_payload;

  logic [PKT_W-1:0]      r_hdr_mem [2][PORTS][SLOTS];
  logic [PKT_W-1:0]      r_pay_mem [2][PORTS][SLOTS];

  logic                  w_start;
  logic                  w_wr_hdr;
  logic                  w_wr_pay;
  logic [c_SLOT_W-1:0]   w_wr_slot;
  logic                  w_wr_last;
  logic [PORTS-1:0]      w_par_bad;
  logic [PKT_W-1:0]      w_hdr_word [PORTS];
  logic                  w_port_ok;
  logic                  w_slot_ok;

  // A frame_start strobe always (re)opens a frame at header slot 0 of the
  // current bank, whatever state the sequencer is in.
  assign w_start   = i_sym_en & i_frame_start;
  assign w_wr_hdr  = rst & (w_start | (i_sym_en & (r_state == S_HDR)));
  assign w_wr_pay  = rst & i_sym_en & ~i_frame_start & (r_state == S_PAY);
  assign w_wr_slot = w_start ? '0 : r_slot;
  assign w_wr_last = (w_wr_slot == c_SLOT_W'(SLOTS - 1));

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      w_par_bad[p]  = ~(^i_decoded_in[p*PKT_W +: PKT_W]);
      w_hdr_word[p] = w_par_bad[p] ? '0 : i_decoded_in[p*PKT_W +: PKT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_slot       <= '0;
      r_bank       <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      r_hdr_perr   <= '0;
    end else begin
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      if (i_sym_en) begin
        if (i_frame_start) begin
          r_sync_err <= (r_state != S_IDLE);
          r_hdr_perr <= w_par_bad;
          if (w_wr_last) begin
            r_state <= S_PAY;
            r_slot  <= '0;
          end else begin
            r_state <= S_HDR;
            r_slot  <= w_wr_slot + 1'b1;
          end
        end else begin
          case (r_state)
            S_HDR: begin
              r_hdr_perr <= r_hdr_perr | w_par_bad;
              if (w_wr_last) begin
                r_state <= S_PAY;
                r_slot  <= '0;
              end else begin
                r_slot  <= r_slot + 1'b1;
              end
            end
            S_PAY: begin
              if (w_wr_last) begin
                r_state      <= S_IDLE;
                r_slot       <= '0;
                r_bank       <= ~r_bank;
                r_frame_done <= 1'b1;
                r_rd_valid   <= 1'b1;
              end else begin
                r_slot <= r_slot + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < PORTS; p++) begin
      if (w_wr_hdr) r_hdr_mem[r_bank][p][w_wr_slot] <= w_hdr_word[p];
      if (w_wr_pay) r_pay_mem[r_bank][p][w_wr_slot] <= i_decoded_in[p*PKT_W +: PKT_W];
    end
  end

  if (PORTS == (1 << c_PORT_W)) begin : g_port_full
    assign w_port_ok = 1'b1;
  end else begin : g_port_rng
    assign w_port_ok = (i_rd_port < c_PORT_W'(PORTS));
  end

  if (SLOTS == (1 << c_SLOT_W)) begin : g_slot_full
    assign w_slot_ok = 1'b1;
  end else begin : g_slot_rng
    assign w_slot_ok = (i_rd_slot < c_SLOT_W'(SLOTS));
  end

  // Reads sample the pre-edge bank_sel, so a read on the swap edge still
  // returns the previously completed bank.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_header  <= '0;
      r_rd_payload <= '0;
    end else if (r_rd_valid && w_port_ok && w_slot_ok) begin
      r_rd_header  <= r_hdr_mem[~r_bank][i_rd_port][i_rd_slot];
      r_rd_payload <= r_pay_mem[~r_bank][i_rd_port][i_rd_slot];
    end else begin
      r_rd_header  <= '0;
      r_rd_payload <= '0;
    end
  end

`ifdef XBAR_PERR_CNT_EN
  for (genvar p = 0; p < PORTS; p++) begin : g_perr_cnt
    logic [7:0] r_cnt;
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_cnt <= 8'd0;
      end else if (i_perr_clr) begin
        r_cnt <= 8'd0;
      end else if (w_wr_hdr && w_par_bad[p] && (r_cnt != 8'hFF)) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
    assign o_perr_cnt[p*8 +: 8] = r_cnt;
  end
`endif

  assign o_rd_header    = r_rd_header;
  assign o_rd_payload   = r_rd_payload;
  assign o_rd_valid     = r_rd_valid;
  assign o_bank_sel     = r_bank;
  assign o_running_slot = r_slot;
  assign o_frame_done   = r_frame_done;
  assign o_hdr_perr     = r_hdr_perr;
  assign o_sync_err     = r_sync_err;

endmodule
`default_nettype wire
